// File: rtl/alarm_timer_if.sv
// Request/expiry handshake, BCD preset and remaining-time bus between the watch and the countdown timer.
interface alarm_timer_if;
    logic       tim_en;
    logic       tim_over;
    logic       busy;
    logic       beep;
    logic [3:0] mindec_set;
    logic [3:0] minone_set;
    logic [3:0] secdec_set;
    logic [3:0] secone_set;
    logic [3:0] mindec_rem;
    logic [3:0] minone_rem;
    logic [3:0] secdec_rem;
    logic [3:0] secone_rem;

    // Handshake: four-phase. The watch raises tim_en and holds it. The timer answers with
    // tim_over on expiry and holds it until tim_en is seen low. tim_en low while busy aborts.
    modport master (
        output tim_en, mindec_set, minone_set, secdec_set, secone_set,
        input  tim_over, busy, beep, mindec_rem, minone_rem, secdec_rem, secone_rem
    );

    modport slave (
        input  tim_en, mindec_set, minone_set, secdec_set, secone_set,
        output tim_over, busy, beep, mindec_rem, minone_rem, secdec_rem, secone_rem
    );
endinterface

// File: rtl/alarm_timer.sv
// BCD mm:ss countdown timer answering the watch's timer request; decrements once per
// TICKS_PER_SEC strobes, then flags expiry and beeps until the request is released.
module alarm_timer #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_en,
    alarm_timer_if.slave bus,
    output logic [1:0]   state_dbg
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    logic [1:0]    state;
    logic [PW-1:0] prescaler;
    logic [15:0]   rem;
    logic          beep_q;
    logic [15:0]   preset;
    logic [15:0]   rem_dec;
    logic          sec_tick;
    logic          last_sec;

    // Tens digits saturate at 5 and ones digits at 9 so an illegal preset still counts sanely.
    always_comb begin
        preset[15:12] = (bus.mindec_set > 4'd5) ? 4'd5 : bus.mindec_set;
        preset[11:8]  = (bus.minone_set > 4'd9) ? 4'd9 : bus.minone_set;
        preset[7:4]   = (bus.secdec_set > 4'd5) ? 4'd5 : bus.secdec_set;
        preset[3:0]   = (bus.secone_set > 4'd9) ? 4'd9 : bus.secone_set;
    end

    always_comb begin
        rem_dec = rem;
        if (rem[3:0] == 4'd0) begin
            rem_dec[3:0] = 4'd9;
            if (rem[7:4] == 4'd0) begin
                rem_dec[7:4] = 4'd5;
                if (rem[11:8] == 4'd0) begin
                    rem_dec[11:8]  = 4'd9;
                    rem_dec[15:12] = rem[15:12] - 4'd1;
                end else begin
                    rem_dec[11:8] = rem[11:8] - 4'd1;
                end
            end else begin
                rem_dec[7:4] = rem[7:4] - 4'd1;
            end
        end else begin
            rem_dec[3:0] = rem[3:0] - 4'd1;
        end
    end

    assign sec_tick = tick_en && (prescaler == PRE_LAST);
    assign last_sec = (rem == 16'h0001);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= 16'h0000;
            prescaler <= '0;
            beep_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beep_q <= 1'b0;
                    if (bus.tim_en) begin
                        rem       <= preset;
                        prescaler <= '0;
                        state     <= (preset == 16'h0000) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (tick_en) begin
                        if (sec_tick) begin
                            prescaler <= '0;
                            rem       <= rem_dec;
                            if (last_sec) state <= DONE;
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end
                    // A release on the same edge as the final second still counts down but never expires.
                    if (!bus.tim_en) begin
                        state     <= IDLE;
                        prescaler <= '0;
                    end
                end
                DONE: begin
                    if (tick_en) beep_q <= ~beep_q;
                    if (!bus.tim_en) begin
                        state  <= IDLE;
                        beep_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.tim_over   = (state == DONE);
    assign bus.beep       = beep_q;
    assign bus.mindec_rem = rem[15:12];
    assign bus.minone_rem = rem[11:8];
    assign bus.secdec_rem = rem[7:4];
    assign bus.secone_rem = rem[3:0];
    assign state_dbg      = state;
endmodule

// File: tb/tb_alarm_timer.sv
// Bench for alarm_timer: two instances (1 and 4 ticks per second) on shared stimulus, checked
// against a seconds-based reference model plus constant vector tables and hand sequences.
module tb_alarm_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_en = 1'b0;
    logic        tim_en = 1'b0;
    logic [15:0] set_v = 16'h0000;
    logic [1:0]  state_a, state_b;

    int n_pass = 0;
    int n_total = 0;

    alarm_timer_if ia();
    alarm_timer_if ib();

    assign ia.tim_en = tim_en;
    assign ib.tim_en = tim_en;
    assign ia.mindec_set = set_v[15:12];
    assign ia.minone_set = set_v[11:8];
    assign ia.secdec_set = set_v[7:4];
    assign ia.secone_set = set_v[3:0];
    assign ib.mindec_set = set_v[15:12];
    assign ib.minone_set = set_v[11:8];
    assign ib.secdec_set = set_v[7:4];
    assign ib.secone_set = set_v[3:0];

    alarm_timer #(.TICKS_PER_SEC(1)) dut_a (
        .clk(clk), .rst(rst), .tick_en(tick_en), .bus(ia.slave), .state_dbg(state_a)
    );
    alarm_timer #(.TICKS_PER_SEC(4)) dut_b (
        .clk(clk), .rst(rst), .tick_en(tick_en), .bus(ib.slave), .state_dbg(state_b)
    );

    always #5 clk = ~clk;

    // Reference model: remaining time as plain seconds; mode 0 idle, 1 counting, 2 expired.
    int tps[2] = '{1, 4};
    int m_mode[2];
    int m_secs[2];
    int m_pre[2];
    bit m_beep[2];

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int preset_secs(logic [15:0] s);
        int mins, secs;
        mins = min_i(int'(s[15:12]), 5) * 10 + min_i(int'(s[11:8]), 9);
        secs = min_i(int'(s[7:4]), 5) * 10 + min_i(int'(s[3:0]), 9);
        return mins * 60 + secs;
    endfunction

    function automatic void model_apply(int k, bit r, bit en, bit tk, logic [15:0] s);
        if (r) begin
            m_mode[k] = 0; m_secs[k] = 0; m_pre[k] = 0; m_beep[k] = 0;
        end else if (m_mode[k] == 0) begin
            m_beep[k] = 0;
            if (en) begin
                m_secs[k] = preset_secs(s);
                m_pre[k]  = 0;
                m_mode[k] = (m_secs[k] == 0) ? 2 : 1;
            end
        end else if (m_mode[k] == 1) begin
            if (tk) begin
                m_pre[k]++;
                if (m_pre[k] == tps[k]) begin
                    m_pre[k] = 0;
                    m_secs[k]--;
                    if (m_secs[k] == 0) m_mode[k] = 2;
                end
            end
            if (!en) begin
                m_mode[k] = 0; m_pre[k] = 0;
            end
        end else begin
            if (tk) m_beep[k] = !m_beep[k];
            if (!en) begin
                m_mode[k] = 0; m_beep[k] = 0;
            end
        end
    endfunction

    function automatic logic [18:0] model_out(int k);
        int mm, ss;
        logic [15:0] r;
        mm = m_secs[k] / 60;
        ss = m_secs[k] % 60;
        r = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        return {r, m_mode[k] == 1, m_mode[k] == 2, m_beep[k]};
    endfunction

    function automatic logic [18:0] got_a();
        return {ia.mindec_rem, ia.minone_rem, ia.secdec_rem, ia.secone_rem, ia.busy, ia.tim_over, ia.beep};
    endfunction

    function automatic logic [18:0] got_b();
        return {ib.mindec_rem, ib.minone_rem, ib.secdec_rem, ib.secone_rem, ib.busy, ib.tim_over, ib.beep};
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got rem=%h busy/over/beep=%b, expected rem=%h busy/over/beep=%b (t=%0t)",
                      name, got[18:3], got[2:0], exp[18:3], exp[2:0], $time);
    endtask

    // Drive one edge's inputs, advance the model and check both instances against it.
    task automatic step(input bit r, input bit en, input bit tk, input logic [15:0] s);
        @(negedge clk);
        rst = r; tim_en = en; tick_en = tk; set_v = s;
        @(posedge clk);
        model_apply(0, r, en, tk, s);
        model_apply(1, r, en, tk, s);
        #1;
        check("model_a", got_a(), model_out(0));
        check("model_b", got_b(), model_out(1));
    endtask

    typedef struct {
        bit          r;
        bit          en;
        bit          tk;
        logic [15:0] set;
        logic [15:0] rem;
        logic [2:0]  flags;  // busy, tim_over, beep
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit en, bit tk, logic [15:0] s, logic [15:0] rem, logic [2:0] fl);
        vec_t v;
        v.r = r; v.en = en; v.tk = tk; v.set = s; v.rem = rem; v.flags = fl;
        vecs.push_back(v);
    endfunction

    initial begin
        // Expected values for the one-tick-per-second instance after each edge.
        add(1, 0, 0, 16'h0003, 16'h0000, 3'b000);
        add(0, 1, 1, 16'h0003, 16'h0003, 3'b100);
        add(0, 1, 0, 16'h0003, 16'h0003, 3'b100);
        add(0, 1, 1, 16'h0003, 16'h0002, 3'b100);
        add(0, 1, 0, 16'h0003, 16'h0002, 3'b100);
        add(0, 1, 1, 16'h0003, 16'h0001, 3'b100);
        add(0, 1, 1, 16'h0003, 16'h0000, 3'b010);
        add(0, 1, 1, 16'h0003, 16'h0000, 3'b011);
        add(0, 1, 0, 16'h0003, 16'h0000, 3'b011);
        add(0, 0, 0, 16'h0003, 16'h0000, 3'b000);
        add(0, 1, 0, 16'h1000, 16'h1000, 3'b100);
        add(0, 1, 1, 16'h1000, 16'h0959, 3'b100);
        add(0, 0, 0, 16'h1000, 16'h0959, 3'b000);
        add(0, 1, 0, 16'h0100, 16'h0100, 3'b100);
        add(0, 1, 1, 16'h0100, 16'h0059, 3'b100);
        add(0, 0, 0, 16'h0100, 16'h0059, 3'b000);
        add(0, 1, 0, 16'h0000, 16'h0000, 3'b010);
        add(0, 0, 0, 16'h0000, 16'h0000, 3'b000);
        add(0, 1, 0, 16'h7FAB, 16'h5959, 3'b100);
        add(0, 0, 0, 16'h7FAB, 16'h5959, 3'b000);
        add(0, 1, 0, 16'h0005, 16'h0005, 3'b100);
        add(0, 1, 1, 16'h0005, 16'h0004, 3'b100);
        add(0, 1, 1, 16'h0005, 16'h0003, 3'b100);
        add(0, 0, 0, 16'h0005, 16'h0003, 3'b000);
        add(0, 0, 1, 16'h0005, 16'h0003, 3'b000);
        add(0, 1, 0, 16'h0005, 16'h0005, 3'b100);
        add(0, 1, 1, 16'h0001, 16'h0004, 3'b100);
        add(0, 0, 0, 16'h0001, 16'h0004, 3'b000);
        add(0, 1, 0, 16'h0001, 16'h0001, 3'b100);
        add(0, 0, 1, 16'h0001, 16'h0000, 3'b000);
        add(0, 0, 1, 16'h0001, 16'h0000, 3'b000);
        add(0, 1, 0, 16'h0327, 16'h0327, 3'b100);
        add(0, 1, 1, 16'h0327, 16'h0326, 3'b100);
        add(1, 1, 0, 16'h0327, 16'h0000, 3'b000);
        add(0, 0, 1, 16'h0327, 16'h0000, 3'b000);
        add(0, 1, 0, 16'h0000, 16'h0000, 3'b010);
        add(0, 1, 1, 16'h0000, 16'h0000, 3'b011);
        add(1, 1, 0, 16'h0000, 16'h0000, 3'b000);
        add(0, 0, 0, 16'h0000, 16'h0000, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].en, vecs[i].tk, vecs[i].set);
            check($sformatf("vec%0d", i), got_a(), {vecs[i].rem, vecs[i].flags});
        end

        // Four strobes per second: decrements land on the 4th and 8th strobe only.
        step(0, 1, 0, 16'h0002);
        check("b_load", got_b(), {16'h0002, 3'b100});
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 1, 16'h0002);
            check($sformatf("b_tick%0d", i), got_b(),
                  (i < 4) ? {16'h0002, 3'b100} : (i < 8) ? {16'h0001, 3'b100} : {16'h0000, 3'b010});
        end
        for (int j = 1; j <= 4; j++) begin
            step(0, 1, 1, 16'h0002);
            check($sformatf("b_beep%0d", j), got_b(), {16'h0000, 2'b01, 1'(j % 2)});
        end
        step(0, 1, 0, 16'h0002);
        check("b_beep_hold", got_b(), {16'h0000, 3'b010});
        step(0, 0, 0, 16'h0002);
        check("b_release", got_b(), {16'h0000, 3'b000});

        // Random traffic, mostly short presets so both instances reach expiry regularly.
        begin
            bit en_r = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                logic [15:0] s;
                if ($urandom_range(0, 59) == 0) en_r = !en_r;
                if ($urandom_range(0, 3) == 0) s = 16'($urandom());
                else s = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
                step($urandom_range(0, 299) == 0, en_r, $urandom_range(0, 2) == 0, s);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
